mem_arbiter: RTL and testbench

//   N-port arbiter between L1 requesters (l1i, l1d, future DMA/peripheral masters) and one backend memory port.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   N-port arbiter between L1/DMA requesters and a single backend memory port.
//   One transaction in flight at a time. The arbitration policy is fixed priority
//   (port 0 highest) or round-robin. Reads that get no response raise a timeout error.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   req_valid/write/addr/wdata  per-port request, addr/wdata packed port i at [i*W +: W]
//   req_ready               one-hot accept pulse (IDLE only)
//   resp_valid              one-hot completion pulse; resp_data/resp_error qualify it
//   stall                   per-port "still waiting" indication
//   mc_req/write/addr/wdata backend request, held stable until mc_ready
//   mc_ready                backend accepts mc_req
//   mc_rvalid/mc_rdata      backend read return (only observed in WAIT_RESP)
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             resp_error,
  output logic [NUM_PORTS-1:0]             stall,
  output logic                             mc_req,
  output logic                             mc_write,
  output logic [ADDR_WIDTH-1:0]            mc_addr,
  output logic [DATA_WIDTH-1:0]            mc_wdata,
  input  logic                             mc_ready,
  input  logic                             mc_rvalid,
  input  logic [DATA_WIDTH-1:0]            mc_rdata
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          grant, rr_idx, g_q, rr_last_q;
  logic [NUM_PORTS-1:0]   grant_oh, g_oh;
  logic                   any_valid, accept, in_idle, in_resp;
  logic                   write_q, err_q, err_d, timeout_hit;
  logic [CW-1:0]          cnt_q, cnt_inc;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;

  assign any_valid = |req_valid;
  assign in_idle   = (state_q == IDLE);
  assign in_resp   = (state_q == RESP);
  assign accept    = in_idle && any_valid;
  assign grant_oh  = NUM_PORTS'(1) << grant;
  assign g_oh      = NUM_PORTS'(1) << g_q;

  // Counter is pre-incremented so the timeout fires in the TIMEOUT-th WAIT_RESP cycle.
  assign cnt_inc     = cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    grant  = '0;
    rr_idx = '0;
    if (RR_MODE != 0) begin
      // Walk downwards so the first valid port after rr_last_q is assigned last and wins.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        rr_idx = PW'((int'(rr_last_q) + k) % NUM_PORTS);
        if (req_valid[rr_idx]) grant = rr_idx;
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_valid[i]) grant = PW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = ISSUE;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (mc_ready) state_d = write_q ? RESP : WAIT_RESP;
      end
      WAIT_RESP: begin
        // Returned data takes precedence over a timeout landing in the same cycle.
        if (mc_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_last_q <= PW'(NUM_PORTS - 1);
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= (state_q == WAIT_RESP && state_d == WAIT_RESP) ? cnt_inc : '0;
      if (accept) begin
        g_q       <= grant;
        rr_last_q <= grant;
        write_q   <= req_write[grant];
      end
    end
  end

  // Transaction payload; consumers only look at it through state-qualified outputs.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
      rdata_q <= '0;
    end else if (state_q == WAIT_RESP && mc_rvalid) begin
      rdata_q <= mc_rdata;
    end
  end

  // Combinational outputs that depend on req_valid are gated so reset forces them low.
  assign req_ready  = (reset && accept) ? grant_oh : '0;
  assign resp_valid = in_resp ? g_oh : '0;
  assign resp_data  = in_resp ? rdata_q : '0;
  assign resp_error = in_resp && err_q;
  assign mc_req     = (state_q == ISSUE);
  assign mc_write   = mc_req && write_q;
  assign mc_addr    = mc_req ? addr_q : '0;
  assign mc_wdata   = mc_req ? wdata_q : '0;

  always_comb begin
    stall = '0;
    if (reset) begin
      if (in_idle) stall = req_valid & ~req_ready;
      else         stall = (req_valid | g_oh) & ~resp_valid;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a fixed-priority 4-port instance with TIMEOUT=4 and a
// round-robin 4-port instance, both driven from one clock and reset.
module tb_mem_arbiter;

  logic          clock = 1'b0;
  logic          reset;

  logic [3:0]    req_valid, req_write, req_ready, resp_valid, stall;
  logic [127:0]  req_addr, req_wdata;
  logic [31:0]   resp_data, mc_addr, mc_wdata, mc_rdata;
  logic          resp_error, mc_req, mc_write, mc_ready, mc_rvalid;

  logic [3:0]    r_req_valid, r_req_write, r_req_ready, r_resp_valid, r_stall;
  logic [127:0]  r_req_addr, r_req_wdata;
  logic [31:0]   r_resp_data, r_mc_addr, r_mc_wdata, r_mc_rdata;
  logic          r_resp_error, r_mc_req, r_mc_write, r_mc_ready, r_mc_rvalid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    int          g;
  } vec_t;

  typedef struct {
    logic [3:0] mask;
    int         g;
  } rr_t;

  vec_t vecs[8];
  rr_t  rr_vec[10];

  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .stall(stall), .mc_req(mc_req), .mc_write(mc_write), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ready(mc_ready), .mc_rvalid(mc_rvalid), .mc_rdata(mc_rdata)
  );

  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT(0)) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(r_req_valid), .req_write(r_req_write), .req_addr(r_req_addr), .req_wdata(r_req_wdata),
    .req_ready(r_req_ready), .resp_valid(r_resp_valid), .resp_data(r_resp_data), .resp_error(r_resp_error),
    .stall(r_stall), .mc_req(r_mc_req), .mc_write(r_mc_write), .mc_addr(r_mc_addr), .mc_wdata(r_mc_wdata),
    .mc_ready(r_mc_ready), .mc_rvalid(r_mc_rvalid), .mc_rdata(r_mc_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ports(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = a + 32'(16 * i);
      req_wdata[i*32 +: 32] = d + 32'(i);
    end
  endtask

  // Runs one complete transaction starting in IDLE just after a rising edge.
  task automatic run_txn(input vec_t v);
    logic [3:0] goh;
    logic       wr;
    goh = 4'b0001 << v.g;
    wr  = v.wmask[v.g];
    req_valid = v.mask;
    req_write = v.wmask;
    set_ports(v.addr, v.wdata);
    @(negedge clock);
    chk("req_ready", req_ready, goh);
    chk("stall_idle", stall, v.mask & ~goh);
    @(posedge clock); #1;
    req_valid = v.mask & ~goh;
    set_ports(32'hFFFF_0000, 32'h0BAD_0000);
    for (int c = 0; c <= v.rdy; c++) begin
      mc_ready = (c == v.rdy);
      @(negedge clock);
      chk("mc_req", mc_req, 1'b1);
      chk("mc_addr", mc_addr, v.addr + 32'(16 * v.g));
      chk("mc_wdata", mc_wdata, v.wdata + 32'(v.g));
      chk("mc_write", mc_write, wr);
      chk("stall_busy", stall, v.mask);
      chk("resp_early", resp_valid, 4'b0000);
      @(posedge clock); #1;
    end
    mc_ready = 1'b0;
    if (!wr) begin
      for (int c = 0; c <= v.rv; c++) begin
        mc_rvalid = (c == v.rv);
        mc_rdata  = (c == v.rv) ? v.rdata : 32'h0BAD_F00D;
        @(negedge clock);
        chk("wait_mc_req", mc_req, 1'b0);
        chk("wait_resp", resp_valid, 4'b0000);
        chk("wait_stall", stall, v.mask);
        @(posedge clock); #1;
      end
      mc_rvalid = 1'b0;
    end
    @(negedge clock);
    chk("resp_valid", resp_valid, goh);
    chk("resp_data", resp_data, wr ? 32'h0 : v.rdata);
    chk("resp_error", resp_error, 1'b0);
    chk("stall_resp", stall, v.mask & ~goh);
    @(posedge clock); #1;
  endtask

  initial begin
    //                 mask     wmask    addr          wdata         rdata         rdy rv g
    vecs[0] = '{4'b0010, 4'b0000, 32'h0000_00F0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1};
    vecs[1] = '{4'b0011, 4'b0000, 32'h0000_1000, 32'h0000_0000, 32'h1111_1111, 0, 1, 0};
    vecs[2] = '{4'b0011, 4'b0011, 32'h0000_2000, 32'hCAFE_0000, 32'h0000_0000, 0, 0, 0};
    vecs[3] = '{4'b0011, 4'b0000, 32'h0000_3000, 32'h0000_0000, 32'h3333_3333, 2, 0, 0};
    vecs[4] = '{4'b1100, 4'b1100, 32'h0000_5000, 32'h1234_5678, 32'h0000_0000, 5, 0, 2};
    vecs[5] = '{4'b1000, 4'b0000, 32'h0000_6000, 32'h0000_0000, 32'h5A5A_5A5A, 0, 3, 3};
    vecs[6] = '{4'b1111, 4'b0001, 32'h0000_7000, 32'h7777_0000, 32'h0000_0000, 1, 0, 0};
    vecs[7] = '{4'b0100, 4'b0000, 32'h0000_8000, 32'h0000_0000, 32'h8888_8888, 0, 2, 2};

    rr_vec[0] = '{4'b1111, 0};
    rr_vec[1] = '{4'b1111, 1};
    rr_vec[2] = '{4'b1111, 2};
    rr_vec[3] = '{4'b1111, 3};
    rr_vec[4] = '{4'b1111, 0};
    rr_vec[5] = '{4'b1010, 1};
    rr_vec[6] = '{4'b1010, 3};
    rr_vec[7] = '{4'b0011, 0};
    rr_vec[8] = '{4'b0100, 2};
    rr_vec[9] = '{4'b0011, 0};

    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mc_ready = 1'b0; mc_rvalid = 1'b0; mc_rdata = '0;
    r_req_valid = '0; r_req_write = '0; r_req_addr = '0; r_req_wdata = '0;
    r_mc_ready = 1'b0; r_mc_rvalid = 1'b0; r_mc_rdata = '0;

    // Reset state, with requests pending so gating is visible.
    #2 reset = 1'b0;
    req_valid = 4'hF;
    r_req_valid = 4'hF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_stall", stall, 4'b0000);
    chk("rst_resp_valid", resp_valid, 4'b0000);
    chk("rst_mc_req", mc_req, 1'b0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_rr_ready", r_req_ready, 4'b0000);
    @(posedge clock); #1;
    req_valid = '0;
    r_req_valid = '0;
    reset = 1'b1;
    @(posedge clock); #1;

    // Fixed-priority transactions from the vector table.
    for (int k = 0; k < 8; k++) run_txn(vecs[k]);
    req_valid = '0;

    // Round-robin grant order on the second instance.
    r_req_write = 4'hF;
    r_mc_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r_req_valid = rr_vec[k].mask;
      @(negedge clock);
      chk("rr_grant", r_req_ready, 4'b0001 << rr_vec[k].g);
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("rr_resp", r_resp_valid, 4'b0001 << rr_vec[k].g);
      @(posedge clock); #1;
    end
    r_req_valid = '0;
    r_mc_ready  = 1'b0;

    // Timeout: read on port 0, stray mc_rvalid while still in ISSUE, then silence.
    req_valid = 4'b0001;
    req_write = 4'b0000;
    set_ports(32'h0000_4000, 32'h0);
    @(negedge clock);
    chk("to_ready", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    mc_ready  = 1'b1;
    mc_rvalid = 1'b1;
    mc_rdata  = 32'h0BAD_F00D;
    @(negedge clock);
    chk("to_mc_req", mc_req, 1'b1);
    @(posedge clock); #1;
    mc_ready  = 1'b0;
    mc_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("to_wait", resp_valid, 4'b0000);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("to_resp_valid", resp_valid, 4'b0001);
    chk("to_resp_error", resp_error, 1'b1);
    chk("to_resp_data", resp_data, 32'h0);
    @(posedge clock); #1;

    // Back in IDLE: start a port-1 read and reset it while waiting for data.
    req_valid = 4'b0010;
    @(negedge clock);
    chk("to_idle_ready", req_ready, 4'b0010);
    @(posedge clock); #1;
    req_valid = 4'b1111;
    mc_ready  = 1'b1;
    @(negedge clock);
    chk("rw_mc_addr", mc_addr, 32'h0000_4010);
    @(posedge clock); #1;
    mc_ready = 1'b0;
    @(posedge clock); #1;
    r_req_valid = 4'hF;
    #2 reset = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 4'b0000);
    chk("arst_req_ready", req_ready, 4'b0000);
    chk("arst_stall", stall, 4'b0000);
    chk("arst_mc_req", mc_req, 1'b0);
    chk("arst_mc_addr", mc_addr, 32'h0);
    chk("arst_resp_data", resp_data, 32'h0);
    chk("arst_resp_error", resp_error, 1'b0);
    chk("arst_rr_ready", r_req_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      mc_rvalid = 1'b1;
      mc_rdata  = 32'hFEED_0000;
      @(negedge clock);
      chk("arst_hold_resp", resp_valid, 4'b0000);
      @(posedge clock); #1;
    end
    mc_rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_grant", req_ready, 4'b0001);
    chk("post_rst_rr_grant", r_req_ready, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
